seq_divider: RTL and testbench

Sequential unsigned restoring divider, the inverse counterpart of the array multiplier in the arithmetic library. It computes quotient and remainder of two WIDTH-bit operands, resolving one quotient bit per clock through a trial-subtract/restore step. A start/done handshake lets it sit beside the multiplier behind the same lab controller.

---
 rtl/seq_divider_if.sv | 15 +
 rtl/seq_divider.sv | 74 +++++++
 tb/tb_seq_divider.sv | 151 +++++++++++++++
 3 files changed

// File: rtl/seq_divider_if.sv
// seq_divider_if: start/done handshake and operand/result bus for seq_divider.
// Ports: start, dividend, divisor (requester to divider); quotient, remainder,
// busy, done, div_by_zero (divider to requester). Modports: master, slave.
interface seq_divider_if #(parameter int WIDTH = 8);
  logic start;
  logic [WIDTH-1:0] dividend;
  logic [WIDTH-1:0] divisor;
  logic [WIDTH-1:0] quotient;
  logic [WIDTH-1:0] remainder;
  logic busy;
  logic done;
  logic div_by_zero;
  modport master(output start, dividend, divisor, input quotient, remainder, busy, done, div_by_zero);
  modport slave(input start, dividend, divisor, output quotient, remainder, busy, done, div_by_zero);
endinterface

// File: rtl/seq_divider.sv
// seq_divider: unsigned restoring divider, one quotient bit per clock, start/done handshake.
// Ports: clk, rst (sync, active-high), bus (seq_divider_if.slave: start, dividend, divisor,
// quotient, remainder, busy, done, div_by_zero). Optional macro DIV_ZERO_CHECK_EN enables
// the early exit and div_by_zero flag for a zero divisor.
module seq_divider #(parameter int WIDTH = 8) (
  input logic clk,
  input logic rst,
  seq_divider_if.slave bus
);
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
  localparam int CW = $clog2(WIDTH + 1);
  state_t state;
  logic [CW-1:0] cnt;
  logic [WIDTH:0] r;
  logic [WIDTH-1:0] q;
  logic [WIDTH-1:0] d;
  logic [WIDTH:0] rs;
  logic [WIDTH:0] t;
  logic accept;
  assign rs = {r[WIDTH-1:0], q[WIDTH-1]};
  assign t = rs - {1'b0, d};
  assign accept = (state != RUN) && bus.start;
  // cnt counts 0..WIDTH: WIDTH iterations, then one cycle to publish results into DONE
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      cnt <= '0;
      r <= '0;
      q <= '0;
      d <= '0;
      bus.quotient <= '0;
      bus.remainder <= '0;
      bus.busy <= 1'b0;
      bus.done <= 1'b0;
      bus.div_by_zero <= 1'b0;
    end else begin
      bus.done <= 1'b0;
      if (accept) begin
        state <= RUN;
        q <= bus.dividend;
        d <= bus.divisor;
        r <= '0;
        cnt <= '0;
        bus.quotient <= '0;
        bus.remainder <= '0;
        bus.div_by_zero <= 1'b0;
        bus.busy <= 1'b1;
      end else if (state == RUN) begin
        if (cnt == CW'(WIDTH)) begin
          state <= DONE;
          bus.busy <= 1'b0;
          bus.done <= 1'b1;
          bus.quotient <= q;
          bus.remainder <= r[WIDTH-1:0];
`ifdef DIV_ZERO_CHECK_EN
        end else if (cnt == '0 && d == '0) begin
          // zero check: q still holds the dividend, so skip straight to the publish cycle
          q <= '1;
          r <= {1'b0, q};
          cnt <= CW'(WIDTH);
          bus.busy <= 1'b0;
          bus.div_by_zero <= 1'b1;
`endif
        end else begin
          r <= t[WIDTH] ? rs : t;
          q <= {q[WIDTH-2:0], ~t[WIDTH]};
          cnt <= cnt + 1'b1;
        end
      end else if (state == DONE) begin
        state <= IDLE;
      end
    end
  end
endmodule

// File: tb/tb_seq_divider.sv
// tb_seq_divider: table-driven, hand-written and randomized checks of seq_divider (WIDTH=8).
module tb_seq_divider;
  localparam int W = 8;
  localparam int MAXV = (1 << W) - 1;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int errors = 0;
  int checks = 0;
  seq_divider_if #(.WIDTH(W)) bus();
  seq_divider #(.WIDTH(W)) dut(.clk(clk), .rst(rst), .bus(bus));
  always #5 clk = ~clk;
  typedef struct {int a; int b; int q; int r;} vec_t;
  vec_t vecs[6];
  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask
  // Higher-level reference: plain division, zero divisor yields all ones / dividend.
  task automatic model(input int a, input int b, output int q, output int r);
    q = (b == 0) ? MAXV : a / b;
    r = (b == 0) ? a : a % b;
  endtask
  // Entered #1 after an edge. Accepts at the next edge N, optionally pulses a second
  // start (9/3) before edge N+pulse_at, returns results seen in the done cycle.
  task automatic run_op(input int a, input int b, input int pulse_at,
                        output int q, output int r, output int z, output int lat, output int bc);
    bus.start = 1'b1;
    bus.dividend = W'(a);
    bus.divisor = W'(b);
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    bus.dividend = W'($urandom);
    bus.divisor = W'($urandom);
    lat = 0;
    bc = 0;
    for (int i = 1; i <= 40; i++) begin
      if (bus.busy) bc++;
      if (i == pulse_at) begin
        bus.start = 1'b1;
        bus.dividend = 8'd9;
        bus.divisor = 8'd3;
      end
      @(posedge clk);
      #1;
      bus.start = 1'b0;
      if (bus.done) begin
        lat = i;
        break;
      end
    end
    q = int'(bus.quotient);
    r = int'(bus.remainder);
    z = int'(bus.div_by_zero);
  endtask
  task automatic check_op(input string nm, input int a, input int b, input int pulse_at,
                          input int eq, input int er);
    int q, r, z, lat, bc, elat, ebc, ez;
`ifdef DIV_ZERO_CHECK_EN
    elat = (b == 0) ? 2 : W + 1;
    ebc = (b == 0) ? 1 : W + 1;
    ez = (b == 0) ? 1 : 0;
`else
    elat = W + 1;
    ebc = W + 1;
    ez = 0;
`endif
    run_op(a, b, pulse_at, q, r, z, lat, bc);
    chk({nm, " latency"}, lat, elat);
    chk({nm, " busy cycles"}, bc, ebc);
    chk({nm, " quotient"}, q, eq);
    chk({nm, " remainder"}, r, er);
    chk({nm, " div_by_zero"}, z, ez);
  endtask
  initial begin
    int mq, mr;
    vecs[0] = '{100, 7, 14, 2};
    vecs[1] = '{255, 1, 255, 0};
    vecs[2] = '{5, 9, 0, 5};
    vecs[3] = '{200, 200, 1, 0};
    vecs[4] = '{42, 0, 255, 42};
    vecs[5] = '{0, 13, 0, 0};
    bus.start = 1'b0;
    bus.dividend = '0;
    bus.divisor = '0;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    chk("reset quotient", int'(bus.quotient), 0);
    chk("reset remainder", int'(bus.remainder), 0);
    chk("reset busy", int'(bus.busy), 0);
    chk("reset done", int'(bus.done), 0);
    chk("reset div_by_zero", int'(bus.div_by_zero), 0);
    foreach (vecs[i]) begin
      check_op($sformatf("vec%0d %0d/%0d", i, vecs[i].a, vecs[i].b), vecs[i].a, vecs[i].b, 0,
               vecs[i].q, vecs[i].r);
      @(posedge clk);
      #1;
      chk("done one-cycle pulse", int'(bus.done), 0);
      chk("idle after done busy", int'(bus.busy), 0);
      chk("result held quotient", int'(bus.quotient), vecs[i].q);
    end
    check_op("ignored start 100/7", 100, 7, 3, 14, 2);
    check_op("back-to-back 9/3", 9, 3, 0, 3, 0);
    @(posedge clk);
    #1;
    bus.start = 1'b1;
    bus.dividend = 8'd100;
    bus.divisor = 8'd7;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("mid-run busy", int'(bus.busy), 1);
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    chk("mid-run reset busy", int'(bus.busy), 0);
    chk("mid-run reset done", int'(bus.done), 0);
    chk("mid-run reset quotient", int'(bus.quotient), 0);
    chk("mid-run reset remainder", int'(bus.remainder), 0);
    repeat (12) @(posedge clk);
    #1;
    chk("idle after reset busy", int'(bus.busy), 0);
    chk("idle after reset done", int'(bus.done), 0);
    check_op("after reset 50/6", 50, 6, 0, 8, 2);
    for (int k = 0; k < 2000; k++) begin
      int a, b, q, r, z, lat, bc;
      a = $urandom_range(0, MAXV);
      b = (k % 4 == 0) ? $urandom_range(1, 15) : $urandom_range(1, MAXV);
      model(a, b, mq, mr);
      run_op(a, b, 0, q, r, z, lat, bc);
      chk($sformatf("rand %0d/%0d quotient", a, b), q, mq);
      chk($sformatf("rand %0d/%0d remainder", a, b), r, mr);
      chk($sformatf("rand %0d/%0d identity", a, b), q * b + r, a);
      chk($sformatf("rand %0d/%0d rem<div", a, b), int'(r < b), 1);
      chk($sformatf("rand %0d/%0d latency", a, b), lat, W + 1);
      if ($urandom_range(0, 1) == 1) begin
        @(posedge clk);
        #1;
      end
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
